// File: rtl/lane_sched_pkg.sv
// Shared types and defaults for the lane result scheduler.
// Imported by the scheduler top and its arbiter.
package lane_sched_pkg;

  typedef enum logic {COLLECT, PRESENT} sched_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_CNT_WIDTH  = 8;

  function automatic int res_width(input int dw, input int nl);
    return dw * nl;
  endfunction

endpackage

// File: rtl/lane_result_scheduler_rr_arbiter.sv
// Rotating-priority one-hot arbiter; search starts at i_ptr.
// Pointer state is owned by the instantiating block.
module rr_arbiter
  import lane_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_LANES,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt
);

  always_comb begin
    logic          w_found;
    logic [PW-1:0] w_idx;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_result_scheduler.sv
// Collects one word per lane into a packed frame, round-robin,
// then hands the full frame downstream over valid/ready.
module lane_result_scheduler
  import lane_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_LANES-1:0] i_req_valid,
  input  logic [res_width(DATA_WIDTH, NUM_LANES)-1:0] i_req_data,
  output logic [NUM_LANES-1:0] o_req_ready,
  input  logic                 i_flush,
  output logic [res_width(DATA_WIDTH, NUM_LANES)-1:0] o_result,
  output logic                 o_result_valid,
  input  logic                 i_result_ready,
  output logic [NUM_LANES-1:0] o_fill_mask,
  output logic [CNT_WIDTH-1:0] o_frame_count
);

  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  logic [NUM_LANES-1:0] r_fill;
  logic [NUM_LANES-1:0] w_fill_nxt;
  logic [NUM_LANES-1:0] w_elig;
  logic [NUM_LANES-1:0] w_gnt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_ptr_nxt;
  logic [PW-1:0]        w_gidx;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_collect;
  logic                 w_en;
  logic                 w_clr;
  logic                 w_acc;
  logic                 w_hand;

  assign w_collect = (r_state == COLLECT);
  assign w_elig    = i_req_valid & ~r_fill;
  // Flush and reset both silence every handshake this cycle.
  assign w_en      = w_collect & ~i_flush & ~i_rst;
  assign w_clr     = w_collect & i_flush;
  assign w_acc     = |w_gnt;
  assign w_hand    = (r_state == PRESENT) & i_result_ready;

  rr_arbiter #(
    .N  (NUM_LANES),
    .PW (PW)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_gnt[i]) w_gidx = PW'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      COLLECT: begin
        if (w_clr) begin
          w_fill_nxt = '0;
        end else if (w_acc) begin
          w_fill_nxt = r_fill | w_gnt;
          w_ptr_nxt  = (w_gidx == PW'(NUM_LANES - 1))
                     ? '0 : w_gidx + 1'b1;
          if (&(r_fill | w_gnt)) w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (i_result_ready) begin
          w_state_nxt = COLLECT;
          w_fill_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= COLLECT;
      r_fill  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_hand) r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_word;
    always_ff @(posedge i_clk) begin
      if (i_rst || w_clr) begin
        r_word <= '0;
      end else if (w_gnt[i]) begin
        r_word <= i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    assign o_result[i*DATA_WIDTH +: DATA_WIDTH] = r_word;
  end

  assign o_req_ready    = w_gnt;
  assign o_result_valid = (r_state == PRESENT);
  assign o_fill_mask    = r_fill;
  assign o_frame_count  = r_cnt;

endmodule

// File: tb/tb_lane_result_scheduler.sv
// Bench for lane_result_scheduler: directed steps plus random
// traffic, checked against a frame-level reference model.
module tb_lane_result_scheduler;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          res_rdy;
  logic [NL-1:0] vld;
  logic [31:0]   data;
  logic [NL-1:0] rdy;
  logic [NL-1:0] fill;
  logic [31:0]   res;
  logic          rv;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  bit [NL-1:0] m_fill;
  bit [31:0]   m_res;
  int          m_ptr;
  bit          m_pres;
  bit [CW-1:0] m_cnt;

  logic [NL-1:0] s_rdy;
  logic [31:0]   s_res;
  logic [CW-1:0] s_cnt;

  always #5 clk = ~clk;

  lane_result_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (vld),
    .i_req_data     (data),
    .o_req_ready    (rdy),
    .i_flush        (flush),
    .o_result       (res),
    .o_result_valid (rv),
    .i_result_ready (res_rdy),
    .o_fill_mask    (fill),
    .o_frame_count  (cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane the reference would accept: first waiting lane from the pointer.
  function automatic bit [NL-1:0] m_grant();
    if (rst || flush || m_pres) return '0;
    for (int k = 0; k < NL; k++) begin
      int l;
      l = (m_ptr + k) % NL;
      if (vld[l] && !m_fill[l]) return NL'(1 << l);
    end
    return '0;
  endfunction

  task automatic cycle();
    bit [NL-1:0] g;
    #1;
    g     = m_grant();
    s_rdy = rdy;
    chk("req_ready", 32'(rdy), 32'(g));
    chk("result", res, m_res);
    chk("result_valid", 32'(rv), 32'(m_pres));
    chk("fill_mask", 32'(fill), 32'(m_fill));
    chk("frame_count", 32'(cnt), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_fill = '0; m_res = '0; m_ptr = 0;
      m_pres = 1'b0; m_cnt = '0;
    end else if (m_pres) begin
      if (res_rdy) begin
        m_pres = 1'b0; m_fill = '0; m_cnt++;
      end
    end else if (flush) begin
      m_fill = '0; m_res = '0;
    end else if (g != '0) begin
      for (int l = 0; l < NL; l++) begin
        if (g[l]) begin
          m_res[l*DW +: DW] = data[l*DW +: DW];
          m_ptr = (l + 1) % NL;
        end
      end
      m_fill |= g;
      if (m_fill == '1) m_pres = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_frame();
    vld     = '1;
    data    = $urandom;
    res_rdy = 1'b1;
    repeat (5) cycle();
  endtask

  initial begin
    // Reset with random inputs
    rst     = 1'b1;
    vld     = NL'($urandom);
    data    = $urandom;
    flush   = 1'($urandom);
    res_rdy = 1'($urandom);
    @(posedge clk);
    m_fill = '0; m_res = '0; m_ptr = 0; m_pres = 1'b0; m_cnt = '0;
    @(negedge clk);
    repeat (2) begin
      vld     = NL'($urandom);
      data    = $urandom;
      flush   = 1'($urandom);
      res_rdy = 1'($urandom);
      cycle();
      chk("rst_ready", 32'(s_rdy), 32'h0);
    end
    rst = 1'b0;
    flush = 1'b0;

    // In-order fill from pointer 0
    vld     = '1;
    data    = 32'hD4C3B2A1;
    res_rdy = 1'b0;
    for (int k = 0; k < NL; k++) begin
      cycle();
      chk("t2_grant", 32'(s_rdy), 32'(1 << k));
    end
    chk("t2_valid", 32'(rv), 32'h1);
    chk("t2_result", res, 32'hD4C3B2A1);

    // Rotation
    res_rdy = 1'b1;
    cycle();
    res_rdy = 1'b0;
    vld  = 4'b0101;
    data = $urandom;
    cycle(); chk("t3a_first", 32'(s_rdy), 32'h1);
    cycle(); chk("t3a_second", 32'(s_rdy), 32'h4);
    vld = 4'b1010;
    cycle(); chk("t3a_third", 32'(s_rdy), 32'h8);
    cycle(); chk("t3a_fourth", 32'(s_rdy), 32'h2);
    res_rdy = 1'b1;
    cycle();
    res_rdy = 1'b0;
    vld  = 4'b0101;
    data = $urandom;
    cycle(); chk("t3b_first", 32'(s_rdy), 32'h4);
    cycle(); chk("t3b_second", 32'(s_rdy), 32'h1);
    vld = 4'b1010;
    cycle(); cycle();
    chk("t3_valid", 32'(rv), 32'h1);

    // Back-pressure while presenting
    vld   = '1;
    data  = $urandom;
    s_res = res;
    s_cnt = cnt;
    repeat (5) begin
      cycle();
      chk("t4_ready", 32'(s_rdy), 32'h0);
      chk("t4_result", res, s_res);
      chk("t4_count", 32'(cnt), 32'(s_cnt));
    end
    res_rdy = 1'b1;
    cycle();
    res_rdy = 1'b0;
    chk("t4_count_inc", 32'(cnt), 32'(CW'(s_cnt + 1)));
    chk("t4_fill_clr", 32'(fill), 32'h0);

    // Flush mid-frame, then flush ignored while presenting
    vld  = 4'b0001;
    data = $urandom;
    cycle();
    vld = 4'b0010;
    cycle();
    chk("t5_fill", 32'(fill), 32'h3);
    flush = 1'b1;
    vld   = 4'b0100;
    cycle();
    chk("t5_ready", 32'(s_rdy), 32'h0);
    flush = 1'b0;
    chk("t5_fill_clr", 32'(fill), 32'h0);
    chk("t5_result_clr", res, 32'h0);
    vld = '1;
    repeat (4) cycle();
    s_res = res;
    flush = 1'b1;
    repeat (2) cycle();
    flush = 1'b0;
    chk("t5_pres_valid", 32'(rv), 32'h1);
    chk("t5_pres_result", res, s_res);
    res_rdy = 1'b1;
    cycle();

    // Random traffic
    repeat (400) begin
      vld     = NL'($urandom);
      data    = $urandom;
      flush   = ($urandom_range(0, 15) == 0);
      res_rdy = 1'($urandom);
      cycle();
    end
    flush = 1'b0;

    // Counter wrap
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (255) do_frame();
    chk("t6_count_ff", 32'(cnt), 32'hFF);
    do_frame();
    chk("t6_wrap", 32'(cnt), 32'h0);

    // Reset mid-frame
    do_frame();
    vld     = 4'b0111;
    data    = $urandom;
    res_rdy = 1'b0;
    repeat (3) cycle();
    chk("t6_partial", 32'(fill), 32'h7);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_rst_fill", 32'(fill), 32'h0);
    chk("t6_rst_valid", 32'(rv), 32'h0);
    chk("t6_rst_count", 32'(cnt), 32'h0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
